cbfp_denorm: RTL and testbench



---
 rtl/cbfp_denorm.sv | 169 ++++++++++++++++
 tb/tb_cbfp_denorm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_denorm.sv
// Restores block-floating-point FFT output (mantissa + per-sample CBFP index) to one
// common fixed-point scale, with saturation and per-frame beat/saturation bookkeeping.
module cbfp_denorm #(
  parameter int IN_W        = 12,
  parameter int OUT_W       = 16,
  parameter int N           = 16,
  parameter int IDX_W       = 5,
  parameter int REF_SHIFT   = 13,
  parameter int FRAME_BEATS = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           valid_in,
  input  logic [IN_W-1:0]                din_i    [N],
  input  logic [IN_W-1:0]                din_q    [N],
  input  logic [IDX_W-1:0]               index_in [N],
  output logic                           valid_out,
  output logic [OUT_W-1:0]               dout_i   [N],
  output logic [OUT_W-1:0]               dout_q   [N],
  output logic [$clog2(FRAME_BEATS)-1:0] beat_idx,
  output logic                           last_out,
  output logic                           sat_flag
);

  // Handshake: valid-only streaming. A beat is accepted on every clock edge where
  // valid_in=1 (no ready, no backpressure); it leaves exactly two edges later with
  // valid_out=1. Outputs other than valid_out hold their value while valid_out=0.

  localparam int BEAT_W = $clog2(FRAME_BEATS);
  localparam int E_W    = IDX_W + 1;
  // Wide enough that m <<< REF_SHIFT can never wrap before the saturation compare.
  localparam int WIDE_W = IN_W + REF_SHIFT + 1;

  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN = WIDE_W'(-(1 << (OUT_W - 1)));

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] y;
  } res_t;

  function automatic res_t restore(input logic [IN_W-1:0] m, input logic signed [E_W-1:0] e);
    logic signed [WIDE_W-1:0] wide;
    logic signed [WIDE_W-1:0] shifted;
    logic [E_W-1:0]           amt;
    res_t                     r;
    wide = WIDE_W'($signed(m));
    if (!e[E_W-1]) begin
      amt     = e;
      shifted = wide <<< amt;
    end else begin
      // Sign fill of >>> gives 0 / -1 once the shift reaches the mantissa width.
      amt     = -e;
      shifted = wide >>> amt;
    end
    if (shifted > SAT_MAX) begin
      r.sat = 1'b1;
      r.y   = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      r.sat = 1'b1;
      r.y   = SAT_MIN[OUT_W-1:0];
    end else begin
      r.sat = 1'b0;
      r.y   = shifted[OUT_W-1:0];
    end
    return r;
  endfunction

  // Stage 1 state
  logic                    s1_valid_q, s1_valid_d;
  logic [BEAT_W-1:0]       s1_beat_q, s1_beat_d;
  logic [BEAT_W-1:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]         s1_mi_q [N];
  logic [IN_W-1:0]         s1_mi_d [N];
  logic [IN_W-1:0]         s1_mq_q [N];
  logic [IN_W-1:0]         s1_mq_d [N];
  logic signed [E_W-1:0]   s1_e_q  [N];
  logic signed [E_W-1:0]   s1_e_d  [N];

  // Stage 2 state
  logic                    valid_out_q, valid_out_d;
  logic [BEAT_W-1:0]       beat_idx_q, beat_idx_d;
  logic                    sat_flag_q, sat_flag_d;
  logic [OUT_W-1:0]        dout_i_q [N];
  logic [OUT_W-1:0]        dout_i_d [N];
  logic [OUT_W-1:0]        dout_q_q [N];
  logic [OUT_W-1:0]        dout_q_d [N];

  res_t                    res_i [N];
  res_t                    res_q [N];
  logic                    beat_sat;

  always_comb begin
    s1_valid_d = valid_in;
    s1_beat_d  = s1_beat_q;
    cnt_d      = cnt_q;
    s1_mi_d    = s1_mi_q;
    s1_mq_d    = s1_mq_q;
    s1_e_d     = s1_e_q;
    if (valid_in) begin
      cnt_d     = (cnt_q == BEAT_W'(FRAME_BEATS - 1)) ? '0 : cnt_q + 1'b1;
      s1_beat_d = cnt_q;
      for (int k = 0; k < N; k++) begin
        s1_mi_d[k] = din_i[k];
        s1_mq_d[k] = din_q[k];
        s1_e_d[k]  = $signed(E_W'(REF_SHIFT) - {1'b0, index_in[k]});
      end
    end
  end

  always_comb begin
    beat_sat    = 1'b0;
    valid_out_d = s1_valid_q;
    beat_idx_d  = beat_idx_q;
    sat_flag_d  = sat_flag_q;
    dout_i_d    = dout_i_q;
    dout_q_d    = dout_q_q;
    for (int k = 0; k < N; k++) begin
      res_i[k] = restore(s1_mi_q[k], s1_e_q[k]);
      res_q[k] = restore(s1_mq_q[k], s1_e_q[k]);
      beat_sat = beat_sat | res_i[k].sat | res_q[k].sat;
    end
    if (s1_valid_q) begin
      beat_idx_d = s1_beat_q;
      // Frame start reloads the sticky flag instead of OR-ing into the old frame.
      sat_flag_d = (s1_beat_q == '0) ? beat_sat : (sat_flag_q | beat_sat);
      for (int k = 0; k < N; k++) begin
        dout_i_d[k] = res_i[k].y;
        dout_q_d[k] = res_q[k].y;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_beat_q   <= '0;
      cnt_q       <= '0;
      s1_mi_q     <= '{default: '0};
      s1_mq_q     <= '{default: '0};
      s1_e_q      <= '{default: '0};
      valid_out_q <= 1'b0;
      beat_idx_q  <= '0;
      sat_flag_q  <= 1'b0;
      dout_i_q    <= '{default: '0};
      dout_q_q    <= '{default: '0};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_beat_q   <= s1_beat_d;
      cnt_q       <= cnt_d;
      s1_mi_q     <= s1_mi_d;
      s1_mq_q     <= s1_mq_d;
      s1_e_q      <= s1_e_d;
      valid_out_q <= valid_out_d;
      beat_idx_q  <= beat_idx_d;
      sat_flag_q  <= sat_flag_d;
      dout_i_q    <= dout_i_d;
      dout_q_q    <= dout_q_d;
    end
  end

  assign valid_out = valid_out_q;
  assign dout_i    = dout_i_q;
  assign dout_q    = dout_q_q;
  assign beat_idx  = beat_idx_q;
  assign sat_flag  = sat_flag_q;
  assign last_out  = valid_out_q && (beat_idx_q == BEAT_W'(FRAME_BEATS - 1));

endmodule

// File: tb/tb_cbfp_denorm.sv
// Directed bench for cbfp_denorm: table of single-beat arithmetic vectors plus
// sequences for frame counting, sticky saturation, valid gaps and mid-frame reset.
module tb_cbfp_denorm;

  localparam int IN_W   = 12;
  localparam int OUT_W  = 16;
  localparam int N      = 16;
  localparam int IDX_W  = 5;
  localparam int FB     = 32;
  localparam int BEAT_W = 5;
  localparam int NV     = 12;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic                valid_in;
  logic [IN_W-1:0]     din_i    [N];
  logic [IN_W-1:0]     din_q    [N];
  logic [IDX_W-1:0]    index_in [N];
  logic                valid_out;
  logic [OUT_W-1:0]    dout_i   [N];
  logic [OUT_W-1:0]    dout_q   [N];
  logic [BEAT_W-1:0]   beat_idx;
  logic                last_out;
  logic                sat_flag;

  cbfp_denorm #(
    .IN_W(IN_W), .OUT_W(OUT_W), .N(N), .IDX_W(IDX_W), .REF_SHIFT(13), .FRAME_BEATS(FB)
  ) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in),
    .din_i(din_i), .din_q(din_q), .index_in(index_in),
    .valid_out(valid_out), .dout_i(dout_i), .dout_q(dout_q),
    .beat_idx(beat_idx), .last_out(last_out), .sat_flag(sat_flag)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [IN_W-1:0]  mi;
    logic [IN_W-1:0]  mq;
    logic [OUT_W-1:0] ei;
    logic [OUT_W-1:0] eq;
    logic             sat;
  } vec_t;

  vec_t vecs [NV];

  int n_tests;
  int n_fail;
  // Scoreboard entry: {beat_idx[4:0], last_out, sat_flag}
  logic [6:0] exp_q[$];
  int   tb_cnt;
  logic vin_d1, vin_d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst valid_out", valid_out, 0);
    check("rst last_out", last_out, 0);
    check("rst sat_flag", sat_flag, 0);
    check("rst beat_idx", beat_idx, 0);
    check("rst dout_i[0]", dout_i[0], 0);
    check("rst dout_q[N-1]", dout_q[N-1], 0);
  endtask

  // Advance to the next falling edge and check the output beat against the scoreboard.
  task automatic tick();
    logic [6:0] e;
    @(negedge clk);
    vin_d2 = vin_d1;
    vin_d1 = valid_in;
    check("valid_out delay", valid_out, vin_d2);
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        check("scoreboard underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat_idx", beat_idx, e[6:2]);
        check("last_out", last_out, e[1]);
        check("sat_flag", sat_flag, e[0]);
      end
    end else begin
      check("last_out idle", last_out, 0);
    end
  endtask

  task automatic push_exp(input logic sat);
    exp_q.push_back({BEAT_W'(tb_cnt), (tb_cnt == FB - 1), sat});
    tb_cnt = (tb_cnt + 1) % FB;
  endtask

  task automatic send_beat(input logic [IDX_W-1:0] idx, input logic [IN_W-1:0] mi,
                           input logic [IN_W-1:0] mq, input logic sat);
    for (int k = 0; k < N; k++) begin
      index_in[k] = idx;
      din_i[k]    = mi;
      din_q[k]    = mq;
    end
    valid_in = 1'b1;
    push_exp(sat);
    tick();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    tb_cnt = 0;
    vin_d1 = 1'b0;
    vin_d2 = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    valid_in = 1'b0;
    tb_cnt   = 0;
    vin_d1   = 1'b0;
    vin_d2   = 1'b0;
    for (int k = 0; k < N; k++) begin
      din_i[k]    = '0;
      din_q[k]    = '0;
      index_in[k] = '0;
    end

    vecs[0]  = '{5'd13, 12'(100),  12'(-100),  16'(100),    16'(-100),   1'b0};
    vecs[1]  = '{5'd10, 12'(100),  12'(-100),  16'(800),    16'(-800),   1'b0};
    vecs[2]  = '{5'd16, 12'(-100), 12'(100),   16'(-13),    16'(12),     1'b0};
    vecs[3]  = '{5'd31, 12'(-1),   12'(5),     16'(-1),     16'(0),      1'b0};
    vecs[4]  = '{5'd0,  12'(2047), 12'(-2048), 16'(32767),  16'(-32768), 1'b1};
    vecs[5]  = '{5'd0,  12'(1),    12'(-1),    16'(8192),   16'(-8192),  1'b0};
    vecs[6]  = '{5'd2,  12'(2047), 12'(3),     16'(32767),  16'(6144),   1'b1};
    vecs[7]  = '{5'd3,  12'(15),   12'(-32),   16'(15360),  16'(-32768), 1'b0};
    vecs[8]  = '{5'd1,  12'(4),    12'(-4),    16'(16384),  16'(-16384), 1'b0};
    vecs[9]  = '{5'd25, 12'(2047), 12'(-2048), 16'(0),      16'(-1),     1'b0};
    vecs[10] = '{5'd24, 12'(2047), 12'(-2048), 16'(0),      16'(-1),     1'b0};
    vecs[11] = '{5'd14, 12'(-1),   12'(3),     16'(-1),     16'(1),      1'b0};

    repeat (2) @(negedge clk);
    check_reset_state();
    rstn = 1'b1;

    // Single-beat arithmetic vectors; data is checked one cycle after valid_out drops.
    for (int v = 0; v < NV; v++) begin
      apply_reset();
      send_beat(vecs[v].idx, vecs[v].mi, vecs[v].mq, vecs[v].sat);
      idle(2);
      for (int k = 0; k < N; k++) begin
        check($sformatf("vec%0d dout_i[%0d]", v, k), dout_i[k], vecs[v].ei);
        check($sformatf("vec%0d dout_q[%0d]", v, k), dout_q[k], vecs[v].eq);
      end
    end

    // Per-lane indices: lane k uses index k.
    apply_reset();
    for (int k = 0; k < N; k++) begin
      index_in[k] = IDX_W'(k);
      din_i[k]    = 12'(1);
      din_q[k]    = 12'(-1);
    end
    valid_in = 1'b1;
    push_exp(1'b0);
    tick();
    idle(2);
    for (int k = 0; k < N; k++) begin
      check($sformatf("lane dout_i[%0d]", k), dout_i[k], (k <= 13) ? 16'(1 << (13 - k)) : 16'(0));
      check($sformatf("lane dout_q[%0d]", k), dout_q[k], (k <= 13) ? 16'(-(1 << (13 - k))) : 16'hffff);
    end

    // Sticky saturation across a frame, hold after last_out, clear on next frame start.
    apply_reset();
    send_beat(5'd0, 12'(2047), 12'(0), 1'b1);
    for (int b = 1; b < FB; b++) send_beat(5'd13, 12'(1), 12'(1), 1'b1);
    idle(4);
    check("sat hold after last", sat_flag, 1);
    send_beat(5'd13, 12'(1), 12'(1), 1'b0);
    send_beat(5'd0, 12'(0), 12'(-2048), 1'b1);
    idle(3);
    check("sat neg dout_q[0]", dout_q[0], 16'h8000);
    check("sat frame scoreboard drained", exp_q.size(), 0);

    // 64 beats with random idle gaps: beat_idx wraps, last_out on beats 32 and 64.
    apply_reset();
    for (int b = 0; b < 2 * FB; b++) begin
      send_beat(5'd13, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(3);
    check("gap scoreboard drained", exp_q.size(), 0);

    // Reset in the middle of a frame with the pipeline occupied.
    apply_reset();
    for (int b = 0; b < 10; b++) send_beat(5'd13, 12'(b * 3), 12'(-b), 1'b0);
    apply_reset();
    idle(3);
    for (int b = 0; b < FB + 2; b++) send_beat(5'd13, 12'(b), 12'(b), 1'b0);
    idle(3);
    check("post-reset scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
